// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - ping-pong framing and latency-tracking shell around a pipelined FFT core
// Inverse frames use conj(FFT(conj(x))): im is negated into and out of the core, saturating at the negative rail.
module fft_frame_sequencer #(
  parameter int LANES     = 16,
  parameter int DIN_W     = 9,
  parameter int DOUT_W    = 13,
  parameter int FRAME_LEN = 512,
  parameter int CORE_LAT  = 160,
  parameter int TAG_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic                    s_inverse,
  input  logic [LANES*DIN_W-1:0]  s_re,
  input  logic [LANES*DIN_W-1:0]  s_im,
  output logic                    core_valid,
  output logic [LANES*DIN_W-1:0]  core_re,
  output logic [LANES*DIN_W-1:0]  core_im,
  input  logic [LANES*DOUT_W-1:0] core_dout_re,
  input  logic [LANES*DOUT_W-1:0] core_dout_im,
  output logic                    m_valid,
  output logic                    m_sop,
  output logic                    m_eop,
  output logic [TAG_W-1:0]        m_tag,
  output logic [LANES*DOUT_W-1:0] m_re,
  output logic [LANES*DOUT_W-1:0] m_im,
  output logic                    err_framing
);

  localparam int B      = FRAME_LEN / LANES;
  localparam int CNT_W  = (B > 1) ? $clog2(B) : 1;
  localparam int ADDR_W = $clog2(2 * B);
  localparam int LW     = TAG_W + 2;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(B - 1);
  localparam logic [ADDR_W-1:0] BANK_B    = ADDR_W'(B);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;
  localparam logic [0:0] DR_IDLE     = 1'b0;
  localparam logic [0:0] DR_DRAIN    = 1'b1;

  function automatic logic [DIN_W-1:0] neg_sat_din(input logic [DIN_W-1:0] x);
    logic [DIN_W-1:0] min_v;
    min_v = {1'b1, {(DIN_W-1){1'b0}}};
    neg_sat_din = (x == min_v) ? ~min_v : (DIN_W'(0) - x);
  endfunction

  function automatic logic [DOUT_W-1:0] neg_sat_dout(input logic [DOUT_W-1:0] x);
    logic [DOUT_W-1:0] min_v;
    min_v = {1'b1, {(DOUT_W-1){1'b0}}};
    neg_sat_dout = (x == min_v) ? ~min_v : (DOUT_W'(0) - x);
  endfunction

  logic [1:0]             r_bank_st  [2];
  logic                   r_bank_inv [2];
  logic [TAG_W-1:0]       r_bank_tag [2];
  logic                   r_wr_bank;
  logic [CNT_W-1:0]       r_wr_cnt;
  logic [TAG_W-1:0]       r_tag_cnt;
  logic                   r_rd_bank;
  logic [CNT_W-1:0]       r_rd_cnt;
  logic [0:0]             r_dr_state;
  logic                   r_core_valid;
  logic [LANES*DIN_W-1:0] r_core_re;
  logic [LANES*DIN_W-1:0] r_core_im;
  logic                   r_core_start;
  logic                   r_core_inv;
  logic [TAG_W-1:0]       r_core_tag;
  logic                   r_err;
  logic [LANES*DIN_W-1:0] r_mem_re [2*B];
  logic [LANES*DIN_W-1:0] r_mem_im [2*B];

  logic [LW-1:0]           r_lat [CORE_LAT];
  logic                    r_out_active;
  logic [CNT_W-1:0]        r_out_cnt;
  logic                    r_out_inv;
  logic [TAG_W-1:0]        r_out_tag;
  logic                    r_m_valid;
  logic                    r_m_sop;
  logic                    r_m_eop;
  logic [TAG_W-1:0]        r_m_tag;
  logic [LANES*DOUT_W-1:0] r_m_re;
  logic [LANES*DOUT_W-1:0] r_m_im;

  logic                    w_wr_fire;
  logic                    w_wr_first;
  logic                    w_wr_inv;
  logic [LANES*DIN_W-1:0]  w_wr_im;
  logic [ADDR_W-1:0]       w_wr_addr;
  logic [ADDR_W-1:0]       w_rd_addr;
  logic                    w_dr_start;
  logic                    w_issue;
  logic                    w_emerge;
  logic                    w_emerge_inv;
  logic [TAG_W-1:0]        w_emerge_tag;
  logic                    w_out_fire;
  logic                    w_out_inv;
  logic [LANES*DOUT_W-1:0] w_m_im;

  assign s_ready    = !rst && ((r_bank_st[r_wr_bank] == ST_EMPTY) || (r_bank_st[r_wr_bank] == ST_FILLING));
  assign w_wr_fire  = s_valid && s_ready;
  assign w_wr_first = (r_wr_cnt == '0);
  // Inverse flag is taken live on beat 0 and from the bank for the rest of the frame.
  assign w_wr_inv   = w_wr_first ? s_inverse : r_bank_inv[r_wr_bank];
  assign w_wr_addr  = (r_wr_bank ? BANK_B : '0) + ADDR_W'(r_wr_cnt);
  assign w_rd_addr  = (r_rd_bank ? BANK_B : '0) + ADDR_W'(r_rd_cnt);
  assign w_dr_start = (r_dr_state == DR_IDLE) && (r_bank_st[r_rd_bank] == ST_FULL);
  assign w_issue    = w_dr_start || (r_dr_state == DR_DRAIN);

  always_comb begin
    w_wr_im = s_im;
    if (w_wr_inv) begin
      for (int l = 0; l < LANES; l++) begin
        w_wr_im[l*DIN_W +: DIN_W] = neg_sat_din(s_im[l*DIN_W +: DIN_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem_re[w_wr_addr] <= s_re;
      r_mem_im[w_wr_addr] <= w_wr_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_st[0]  <= ST_EMPTY;
      r_bank_st[1]  <= ST_EMPTY;
      r_bank_inv[0] <= 1'b0;
      r_bank_inv[1] <= 1'b0;
      r_bank_tag[0] <= '0;
      r_bank_tag[1] <= '0;
      r_wr_bank     <= 1'b0;
      r_wr_cnt      <= '0;
      r_tag_cnt     <= '0;
      r_rd_bank     <= 1'b0;
      r_rd_cnt      <= '0;
      r_dr_state    <= DR_IDLE;
      r_core_valid  <= 1'b0;
      r_core_re     <= '0;
      r_core_im     <= '0;
      r_core_start  <= 1'b0;
      r_core_inv    <= 1'b0;
      r_core_tag    <= '0;
      r_err         <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_wr_fire) begin
        r_err <= (s_last != (r_wr_cnt == LAST_BEAT));
        if (w_wr_first) begin
          r_bank_st[r_wr_bank]  <= ST_FILLING;
          r_bank_inv[r_wr_bank] <= s_inverse;
          r_bank_tag[r_wr_bank] <= r_tag_cnt;
          r_tag_cnt             <= r_tag_cnt + 1'b1;
        end
        if (r_wr_cnt == LAST_BEAT) begin
          r_bank_st[r_wr_bank] <= ST_FULL;
          r_wr_cnt             <= '0;
          r_wr_bank            <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end

      r_core_valid <= w_issue;
      r_core_re    <= w_issue ? r_mem_re[w_rd_addr] : '0;
      r_core_im    <= w_issue ? r_mem_im[w_rd_addr] : '0;
      r_core_start <= w_dr_start;
      if (w_dr_start) begin
        r_core_inv           <= r_bank_inv[r_rd_bank];
        r_core_tag           <= r_bank_tag[r_rd_bank];
        r_bank_st[r_rd_bank] <= ST_DRAINING;
        r_rd_cnt             <= CNT_W'(1);
        r_dr_state           <= DR_DRAIN;
      end else if (r_dr_state == DR_DRAIN) begin
        // Returning to IDLE here lets a waiting FULL bank start on the very next edge.
        if (r_rd_cnt == LAST_BEAT) begin
          r_bank_st[r_rd_bank] <= ST_EMPTY;
          r_rd_cnt             <= '0;
          r_rd_bank            <= ~r_rd_bank;
          r_dr_state           <= DR_IDLE;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
    end
  end

  assign w_emerge     = r_lat[CORE_LAT-1][LW-1];
  assign w_emerge_inv = r_lat[CORE_LAT-1][TAG_W];
  assign w_emerge_tag = r_lat[CORE_LAT-1][TAG_W-1:0];
  assign w_out_fire   = w_emerge || r_out_active;
  assign w_out_inv    = w_emerge ? w_emerge_inv : r_out_inv;

  always_comb begin
    w_m_im = core_dout_im;
    if (w_out_inv) begin
      for (int l = 0; l < LANES; l++) begin
        w_m_im[l*DOUT_W +: DOUT_W] = neg_sat_dout(core_dout_im[l*DOUT_W +: DOUT_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORE_LAT; i++) r_lat[i] <= '0;
      r_out_active <= 1'b0;
      r_out_cnt    <= '0;
      r_out_inv    <= 1'b0;
      r_out_tag    <= '0;
      r_m_valid    <= 1'b0;
      r_m_sop      <= 1'b0;
      r_m_eop      <= 1'b0;
      r_m_tag      <= '0;
      r_m_re       <= '0;
      r_m_im       <= '0;
    end else begin
      r_lat[0] <= {r_core_start, r_core_inv, r_core_tag};
      for (int i = 1; i < CORE_LAT; i++) r_lat[i] <= r_lat[i-1];
      r_m_valid <= w_out_fire;
      r_m_re    <= w_out_fire ? core_dout_re : '0;
      r_m_im    <= w_out_fire ? w_m_im : '0;
      // A start emerging on the counter's last beat simply reloads it.
      if (w_emerge) begin
        r_m_sop      <= 1'b1;
        r_m_eop      <= 1'b0;
        r_m_tag      <= w_emerge_tag;
        r_out_cnt    <= CNT_W'(1);
        r_out_active <= 1'b1;
        r_out_inv    <= w_emerge_inv;
        r_out_tag    <= w_emerge_tag;
      end else if (r_out_active) begin
        r_m_sop      <= 1'b0;
        r_m_eop      <= (r_out_cnt == LAST_BEAT);
        r_m_tag      <= r_out_tag;
        r_out_cnt    <= (r_out_cnt == LAST_BEAT) ? '0 : r_out_cnt + 1'b1;
        r_out_active <= (r_out_cnt != LAST_BEAT);
      end else begin
        r_m_sop <= 1'b0;
        r_m_eop <= 1'b0;
        r_m_tag <= '0;
      end
    end
  end

  assign core_valid  = r_core_valid;
  assign core_re     = r_core_re;
  assign core_im     = r_core_im;
  assign m_valid     = r_m_valid;
  assign m_sop       = r_m_sop;
  assign m_eop       = r_m_eop;
  assign m_tag       = r_m_tag;
  assign m_re        = r_m_re;
  assign m_im        = r_m_im;
  assign err_framing = r_err;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - scoreboard bench for fft_frame_sequencer with a pure-delay core stub
module tb_fft_frame_sequencer;
  localparam int LANES = 16, DIN_W = 9, DOUT_W = 13, FRAME_LEN = 512, CORE_LAT = 160, TAG_W = 4;
  localparam int B = FRAME_LEN / LANES;

  logic clk, rst, s_valid, s_ready, s_last, s_inverse;
  logic [LANES*DIN_W-1:0]  s_re, s_im, core_re, core_im;
  logic core_valid, m_valid, m_sop, m_eop, err_framing;
  logic [LANES*DOUT_W-1:0] core_dout_re, core_dout_im, m_re, m_im;
  logic [TAG_W-1:0]        m_tag;

  fft_frame_sequencer #(.LANES(LANES), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .FRAME_LEN(FRAME_LEN),
                        .CORE_LAT(CORE_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_inverse(s_inverse), .s_re(s_re), .s_im(s_im), .core_valid(core_valid),
    .core_re(core_re), .core_im(core_im), .core_dout_re(core_dout_re),
    .core_dout_im(core_dout_im), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
    .m_tag(m_tag), .m_re(m_re), .m_im(m_im), .err_framing(err_framing));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: CORE_LAT-cycle delay, sign-extending each lane.
  logic [LANES*DOUT_W-1:0] dl_re [CORE_LAT];
  logic [LANES*DOUT_W-1:0] dl_im [CORE_LAT];
  logic force_min = 1'b0;

  function automatic logic [LANES*DOUT_W-1:0] sext_vec(input logic [LANES*DIN_W-1:0] v);
    logic [LANES*DOUT_W-1:0] o;
    for (int l = 0; l < LANES; l++)
      o[l*DOUT_W +: DOUT_W] = {{(DOUT_W-DIN_W){v[l*DIN_W+DIN_W-1]}}, v[l*DIN_W +: DIN_W]};
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORE_LAT; i++) begin dl_re[i] <= '0; dl_im[i] <= '0; end
    end else begin
      dl_re[0] <= sext_vec(core_re);
      dl_im[0] <= sext_vec(core_im);
      for (int i = 1; i < CORE_LAT; i++) begin dl_re[i] <= dl_re[i-1]; dl_im[i] <= dl_im[i-1]; end
    end
  end

  assign core_dout_re = dl_re[CORE_LAT-1];
  always_comb begin
    core_dout_im = dl_im[CORE_LAT-1];
    if (force_min) core_dout_im[DOUT_W-1:0] = 13'h1000;
  end

  typedef struct packed {
    logic [LANES*DOUT_W-1:0] re;
    logic [LANES*DOUT_W-1:0] im;
    logic sop;
    logic eop;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;
  int errors = 0, checks = 0;
  logic mon_en = 1'b0, chk_burst = 1'b1;
  int m_run = 0, m_run_last = 0, m_first_cyc = 0;
  int core_run = 0, core_run_last = 0;
  logic [DIN_W-1:0] core_first_im0;
  logic [TAG_W-1:0] last_sop_tag;
  int err_pulses = 0, last_acc_edge = 0, accepted = 0, stalls = 0;
  logic [TAG_W-1:0] exp_tag = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_valid === 1'b1) begin
        m_run++;
        if (m_run == 1) m_first_cyc = cyc;
        if (m_sop === 1'b1) last_sop_tag = m_tag;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: m_valid=1 at cycle %0d, expected no output", cyc);
        end else begin
          e_mon = sb_q.pop_front();
          if ({m_re, m_im, m_sop, m_eop, m_tag} !== e_mon) begin
            errors++;
            $display("FAIL sb_beat: got re=%h im=%h sop=%b eop=%b tag=%0d expected re=%h im=%h sop=%b eop=%b tag=%0d",
                     m_re, m_im, m_sop, m_eop, m_tag, e_mon.re, e_mon.im, e_mon.sop, e_mon.eop, e_mon.tag);
          end
        end
      end else begin
        if (m_run != 0) begin m_run_last = m_run; m_run = 0; end
        checks++;
        if ({m_re, m_im, m_sop, m_eop} !== '0) begin
          errors++;
          $display("FAIL m_idle_zero: got re=%h im=%h sop=%b eop=%b expected all 0", m_re, m_im, m_sop, m_eop);
        end
      end
      if (core_valid === 1'b1) begin
        core_run++;
        if (core_run == 1) core_first_im0 = core_im[DIN_W-1:0];
      end else begin
        if (core_run != 0) begin
          core_run_last = core_run;
          if (chk_burst) begin
            checks++;
            if (core_run % B != 0) begin
              errors++;
              $display("FAIL core_burst: got burst length %0d expected multiple of %0d", core_run, B);
            end
          end
          core_run = 0;
        end
        checks++;
        if ({core_re, core_im} !== '0) begin
          errors++;
          $display("FAIL core_idle_zero: got re=%h im=%h expected 0", core_re, core_im);
        end
      end
      if (err_framing === 1'b1) err_pulses++;
    end
  end

  function automatic int clamp_pos(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic push_beat(input logic [LANES*DIN_W-1:0] re_v, input logic [LANES*DIN_W-1:0] im_v,
                           input bit inv, input int b);
    exp_t e;
    int ri, ii, di;
    for (int l = 0; l < LANES; l++) begin
      ri = $signed(re_v[l*DIN_W +: DIN_W]);
      ii = $signed(im_v[l*DIN_W +: DIN_W]);
      if (inv) ii = clamp_pos(-ii, 255);
      di = ii;
      if (force_min && l == 0) di = -4096;
      if (inv) di = clamp_pos(-di, 4095);
      e.re[l*DOUT_W +: DOUT_W] = ri[DOUT_W-1:0];
      e.im[l*DOUT_W +: DOUT_W] = di[DOUT_W-1:0];
    end
    e.sop = (b == 0);
    e.eop = (b == B - 1);
    e.tag = exp_tag;
    sb_q.push_back(e);
  endtask

  // style 0: ramp re=beat, im=0; 1: random; 2: random with lane-0 im=-256
  task automatic send_frames(input int nfr, input bit inv, input int style, input int gap_pct,
                             input int bad_beat, input bit drop_last);
    logic [LANES*DIN_W-1:0] re_v, im_v;
    logic lst;
    bit sent;
    int tries;
    for (int f = 0; f < nfr; f++) begin
      for (int b = 0; b < B; b++) begin
        for (int l = 0; l < LANES; l++) begin
          re_v[l*DIN_W +: DIN_W] = (style == 0) ? DIN_W'(b) : DIN_W'($urandom);
          im_v[l*DIN_W +: DIN_W] = (style == 0) ? '0 : DIN_W'($urandom);
        end
        if (style == 2) im_v[DIN_W-1:0] = 9'h100;
        lst = (b == B - 1);
        if (b == bad_beat) lst = 1'b1;
        if (drop_last && b == B - 1) lst = 1'b0;
        sent = 0;
        tries = 0;
        while (!sent && tries < 2000) begin
          @(negedge clk);
          tries++;
          if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            s_valid = 1'b0;
          end else begin
            s_valid = 1'b1; s_re = re_v; s_im = im_v; s_last = lst; s_inverse = inv;
            #1;
            if (s_ready) begin
              sent = 1;
              push_beat(re_v, im_v, inv, b);
              last_acc_edge = cyc + 1;
              accepted++;
            end else begin
              stalls++;
            end
          end
        end
        checks++;
        if (!sent) begin
          errors++;
          $display("FAIL send_timeout: beat %0d of frame %0d not accepted, expected acceptance", b, f);
        end
      end
      exp_tag = exp_tag + 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_drain;
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    sb_q.delete();
    exp_tag = '0;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    err_pulses = 0; accepted = 0; stalls = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL rst_core_valid: got %b expected 0", core_valid); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
    checks++; if ({err_framing, m_tag} !== '0) begin errors++; $display("FAIL rst_misc: got err=%b tag=%0d expected 0", err_framing, m_tag); end
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", s_ready); end
    sb_q.delete(); exp_tag = '0;
    @(negedge clk);
  endtask

  task automatic test_single_forward;
    do_reset();
    send_frames(1, 1'b0, 0, 0, -1, 1'b0);
    wait_drain();
    checks++; if (m_first_cyc - last_acc_edge != CORE_LAT + 2) begin errors++; $display("FAIL fwd_latency: got %0d expected %0d", m_first_cyc - last_acc_edge, CORE_LAT + 2); end
    checks++; if (core_run_last != B) begin errors++; $display("FAIL fwd_core_run: got %0d expected %0d", core_run_last, B); end
    checks++; if (m_run_last != B) begin errors++; $display("FAIL fwd_m_run: got %0d expected %0d", m_run_last, B); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    send_frames(2, 1'b0, 1, 0, -1, 1'b0);
    wait_drain();
    checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
    checks++; if (core_run_last != 2 * B) begin errors++; $display("FAIL b2b_core_run: got %0d expected %0d", core_run_last, 2 * B); end
    checks++; if (m_run_last != 2 * B) begin errors++; $display("FAIL b2b_m_run: got %0d expected %0d", m_run_last, 2 * B); end
  endtask

  task automatic test_inverse;
    do_reset();
    force_min = 1'b1;
    send_frames(1, 1'b1, 2, 0, -1, 1'b0);
    wait_drain();
    force_min = 1'b0;
    checks++; if (core_first_im0 !== 9'd255) begin errors++; $display("FAIL inv_core_im: got %0d expected 255", core_first_im0); end
  endtask

  task automatic test_random_gaps;
    do_reset();
    send_frames(3, 1'b0, 1, 50, -1, 1'b0);
    wait_drain();
    checks++; if (accepted != 3 * B) begin errors++; $display("FAIL gaps_accepted: got %0d expected %0d", accepted, 3 * B); end
  endtask

  task automatic test_framing_error;
    do_reset();
    send_frames(1, 1'b0, 1, 0, 20, 1'b1);
    send_frames(1, 1'b1, 1, 0, -1, 1'b0);
    wait_drain();
    checks++; if (err_pulses != 2) begin errors++; $display("FAIL framing_pulses: got %0d expected 2", err_pulses); end
    checks++; if (last_sop_tag !== 4'd1) begin errors++; $display("FAIL framing_tag: got %0d expected 1", last_sop_tag); end
  endtask

  task automatic test_reset_mid_drain;
    int n;
    int hi;
    do_reset();
    chk_burst = 1'b0;
    send_frames(1, 1'b0, 1, 0, -1, 1'b0);
    n = 0;
    while (core_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL rstmid_core_valid: got %b expected 0", core_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_s_ready: got %b expected 0", s_ready); end
    sb_q.delete(); exp_tag = '0;
    @(negedge clk);
    rst = 1'b0;
    chk_burst = 1'b1;
    hi = 0;
    for (int i = 0; i < CORE_LAT + 2; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL rstmid_m_quiet: got %0d valid cycles expected 0", hi); end
    send_frames(1, 1'b0, 1, 0, -1, 1'b0);
    wait_drain();
    checks++; if (last_sop_tag !== 4'd0) begin errors++; $display("FAIL rstmid_tag: got %0d expected 0", last_sop_tag); end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_inverse = 1'b0; s_re = '0; s_im = '0;
    test_reset();
    mon_en = 1'b1;
    test_single_forward();
    test_back_to_back();
    test_inverse();
    test_random_gaps();
    test_framing_error();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
